// File: rtl/mult_pkg.sv
// Shared types for the RV32M multiply front-end.
package mult_pkg;

    typedef enum logic [1:0] {
        MUL    = 2'b00,
        MULH   = 2'b01,
        MULHSU = 2'b10,
        MULHU  = 2'b11
    } mul_op_e;

    typedef enum logic [1:0] {
        StIdle   = 2'b00,
        StSettle = 2'b01,
        StFix    = 2'b10,
        StDone   = 2'b11
    } mult_state_e;

    localparam int unsigned MULT_LAT_DEF = 2;

endpackage

// File: rtl/wall_tree.sv
// Combinational signed 32x32 -> 64 multiplier array; needs several cycles to settle.
module wall_tree (
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [63:0] f
);

    logic signed [63:0] a_ext;
    logic signed [63:0] b_ext;

    assign a_ext = {{32{a[31]}}, a};
    assign b_ext = {{32{b[31]}}, b};
    assign f     = a_ext * b_ext;

endmodule

// File: rtl/mult_unit.sv
// RV32M multiply front-end: one op in flight through a multi-cycle signed wall_tree,
// with unsigned high-word correction applied after the product settles.
module mult_unit
    import mult_pkg::*;
#(
    parameter int unsigned MULT_LAT = MULT_LAT_DEF,
    parameter int unsigned TAG_W    = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [1:0]       req_op,
    input  logic [31:0]      req_a,
    input  logic [31:0]      req_b,
    input  logic [TAG_W-1:0] req_tag,
    input  logic             flush,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic [31:0]      resp_data,
    output logic [TAG_W-1:0] resp_tag,
    output logic             busy
);

    localparam int unsigned CntW = (MULT_LAT > 1) ? $clog2(MULT_LAT) : 1;

    mult_state_e      state_q, state_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic [31:0]      a_q, b_q;
    mul_op_e          op_q;
    logic [TAG_W-1:0] tag_q;
    logic [63:0]      prod_q;
    logic [63:0]      tree_f;
    logic             resp_valid_q;
    logic [31:0]      resp_data_q;
    logic [TAG_W-1:0] resp_tag_q;

    logic             accept, capture, load_resp, clear_resp;
    logic [31:0]      hi, corr_b, corr_a, result;

    wall_tree u_wall_tree (
        .a (a_q),
        .b (b_q),
        .f (tree_f)
    );

    // Flush overrides every state, including a request arriving in the same cycle.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        accept     = 1'b0;
        capture    = 1'b0;
        load_resp  = 1'b0;
        clear_resp = 1'b0;
        if (flush) begin
            state_d    = StIdle;
            clear_resp = 1'b1;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (req_valid) begin
                        accept  = 1'b1;
                        cnt_d   = CntW'(MULT_LAT - 1);
                        state_d = StSettle;
                    end
                end
                StSettle: begin
                    if (cnt_q == '0) begin
                        capture = 1'b1;
                        state_d = StFix;
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
                StFix: begin
                    load_resp = 1'b1;
                    state_d   = StDone;
                end
                StDone: begin
                    if (resp_ready) begin
                        clear_resp = 1'b1;
                        state_d    = StIdle;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    // Signed product plus 2^32-weighted corrections turns it into the su/uu high word.
    always_comb begin
        hi     = prod_q[63:32];
        corr_b = b_q[31] ? a_q : 32'd0;
        corr_a = a_q[31] ? b_q : 32'd0;
        result = prod_q[31:0];
        unique case (op_q)
            MUL:     result = prod_q[31:0];
            MULH:    result = hi;
            MULHSU:  result = hi + corr_b;
            MULHU:   result = hi + corr_b + corr_a;
            default: result = prod_q[31:0];
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q          <= '0;
            b_q          <= '0;
            op_q         <= MUL;
            tag_q        <= '0;
            prod_q       <= '0;
            resp_valid_q <= 1'b0;
            resp_data_q  <= '0;
            resp_tag_q   <= '0;
        end else begin
            if (accept) begin
                a_q   <= req_a;
                b_q   <= req_b;
                op_q  <= mul_op_e'(req_op);
                tag_q <= req_tag;
            end
            if (capture) begin
                prod_q <= tree_f;
            end
            if (load_resp) begin
                resp_valid_q <= 1'b1;
                resp_data_q  <= result;
                resp_tag_q   <= tag_q;
            end else if (clear_resp) begin
                resp_valid_q <= 1'b0;
            end
        end
    end

    assign req_ready  = (state_q == StIdle);
    assign busy       = (state_q != StIdle);
    assign resp_valid = resp_valid_q;
    assign resp_data  = resp_data_q;
    assign resp_tag   = resp_tag_q;

endmodule

// File: tb/tb_mult_unit.sv
// Directed and random checks of mult_unit against a plain-arithmetic RV32M reference.
module tb_mult_unit;
    import mult_pkg::*;

    localparam int unsigned MULT_LAT = 2;
    localparam int unsigned TAG_W    = 5;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             req_valid;
    logic             req_ready;
    logic [1:0]       req_op;
    logic [31:0]      req_a;
    logic [31:0]      req_b;
    logic [TAG_W-1:0] req_tag;
    logic             flush;
    logic             resp_valid;
    logic             resp_ready;
    logic [31:0]      resp_data;
    logic [TAG_W-1:0] resp_tag;
    logic             busy;

    int vectors     = 0;
    int miscompares = 0;

    mult_unit #(
        .MULT_LAT (MULT_LAT),
        .TAG_W    (TAG_W)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_op     (req_op),
        .req_a      (req_a),
        .req_b      (req_b),
        .req_tag    (req_tag),
        .flush      (flush),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_data  (resp_data),
        .resp_tag   (resp_tag),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #2ms;
        $display("FAIL watchdog: observed timeout, expected finish");
        $fatal(1, "watchdog");
    end

    // Exact product of the operands as extended by the opcode, taken mod 2^64.
    function automatic logic [31:0] ref_mul(input logic [1:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
        logic [63:0] ea, eb, p;
        ea = (op == MULHU) ? {32'd0, a} : {{32{a[31]}}, a};
        eb = (op == MULHSU || op == MULHU) ? {32'd0, b} : {{32{b[31]}}, b};
        p  = ea * eb;
        return (op == MUL) ? p[31:0] : p[63:32];
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Issue one op from IDLE, check acceptance-to-valid latency, data and tag, then drain.
    task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [TAG_W-1:0] tag, input logic [31:0] exp);
        int edges;
        req_valid = 1'b1;
        req_op    = op;
        req_a     = a;
        req_b     = b;
        req_tag   = tag;
        check("req_ready_idle", 64'(req_ready), 64'd1);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_a     = $urandom;
        req_b     = $urandom;
        req_tag   = TAG_W'($urandom);
        edges     = 0;
        while (!resp_valid && edges < 20) begin
            @(posedge clk);
            #1;
            edges++;
        end
        check("latency", 64'(edges), 64'(MULT_LAT + 1));
        check("resp_data", 64'(resp_data), 64'(exp));
        check("resp_tag", 64'(resp_tag), 64'(tag));
        @(posedge clk);
        #1;
        check("drain_valid", 64'(resp_valid), 64'd0);
    endtask

    initial begin
        logic [1:0]       op;
        logic [31:0]      a, b, exp_data;
        logic [TAG_W-1:0] tag;
        int               edges;
        bit               seen;

        rst_n      = 1'b0;
        req_valid  = 1'b0;
        req_op     = 2'b00;
        req_a      = '0;
        req_b      = '0;
        req_tag    = '0;
        flush      = 1'b0;
        resp_ready = 1'b1;
        #12;
        check("rst_resp_valid", 64'(resp_valid), 64'd0);
        check("rst_req_ready", 64'(req_ready), 64'd1);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_resp_data", 64'(resp_data), 64'd0);
        check("rst_resp_tag", 64'(resp_tag), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        run_op(MUL, 32'd5, 32'd6, 5'd3, 32'd30);
        run_op(MULH, 32'hFFFF_FFFB, 32'd6, 5'd7, 32'hFFFF_FFFF);
        run_op(MULH, 32'h8000_0000, 32'h8000_0000, 5'd9, 32'h4000_0000);
        run_op(MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd17, 32'hFFFF_FFFE);
        run_op(MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd31, 32'hFFFF_FFFF);

        for (int i = 0; i < 40; i++) begin
            op  = 2'($urandom_range(0, 3));
            a   = $urandom;
            b   = $urandom;
            if (i % 8 == 0) a[31] = 1'b1;
            if (i % 8 == 1) b[31] = 1'b1;
            tag = TAG_W'($urandom);
            run_op(op, a, b, tag, ref_mul(op, a, b));
        end

        // Backpressure: result and tag must hold while the consumer stalls.
        a = $urandom | 32'h8000_0000;
        b = $urandom | 32'h8000_0000;
        exp_data   = ref_mul(MULHU, a, b);
        resp_ready = 1'b0;
        req_valid  = 1'b1;
        req_op     = MULHU;
        req_a      = a;
        req_b      = b;
        req_tag    = 5'd21;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        edges     = 0;
        while (!resp_valid && edges < 20) begin
            @(posedge clk);
            #1;
            edges++;
        end
        check("bp_latency", 64'(edges), 64'(MULT_LAT + 1));
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            check("bp_valid", 64'(resp_valid), 64'd1);
            check("bp_data", 64'(resp_data), 64'(exp_data));
            check("bp_tag", 64'(resp_tag), 64'd21);
            check("bp_req_ready", 64'(req_ready), 64'd0);
        end
        resp_ready = 1'b1;
        @(posedge clk);
        #1;
        check("bp_release_valid", 64'(resp_valid), 64'd0);
        check("bp_release_ready", 64'(req_ready), 64'd1);

        // Flush during SETTLE: op abandoned, no response ever appears.
        req_valid = 1'b1;
        req_op    = MUL;
        req_a     = 32'd11;
        req_b     = 32'd13;
        req_tag   = 5'd4;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        check("settle_busy", 64'(busy), 64'd1);
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        check("flush_busy", 64'(busy), 64'd0);
        seen = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            #1;
            if (resp_valid) seen = 1'b1;
        end
        check("flush_no_resp", 64'(seen), 64'd0);

        // Flush beats a simultaneous request in IDLE.
        req_valid = 1'b1;
        flush     = 1'b1;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        flush     = 1'b0;
        check("flush_req_busy", 64'(busy), 64'd0);
        check("flush_req_ready", 64'(req_ready), 64'd1);

        // Async reset in FIX clears outputs holding a nonzero earlier result.
        run_op(MUL, 32'd7, 32'd9, 5'd12, 32'd63);
        req_valid = 1'b1;
        req_op    = MULH;
        req_a     = $urandom;
        req_b     = $urandom;
        req_tag   = 5'd25;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        for (int i = 0; i < MULT_LAT; i++) begin
            @(posedge clk);
            #1;
        end
        check("fix_resp_data_pre", 64'(resp_data), 64'd63);
        rst_n = 1'b0;
        #1;
        check("mid_rst_valid", 64'(resp_valid), 64'd0);
        check("mid_rst_data", 64'(resp_data), 64'd0);
        check("mid_rst_tag", 64'(resp_tag), 64'd0);
        check("mid_rst_busy", 64'(busy), 64'd0);
        check("mid_rst_ready", 64'(req_ready), 64'd1);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        run_op(MULHSU, 32'h8000_0001, 32'hC000_0000, 5'd2,
               ref_mul(MULHSU, 32'h8000_0001, 32'hC000_0000));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
